// File: rtl/mips_rtype_pkg.sv
// Shared encodings for the R-type execution controller: opcode/funct values,
// controller states, ALU operation codes and the funct-to-ALU decode.
package mips_rtype_pkg;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;

    localparam logic [5:0] FUNCT_ADD  = 6'b100000;
    localparam logic [5:0] FUNCT_SUB  = 6'b100010;
    localparam logic [5:0] FUNCT_AND  = 6'b100100;
    localparam logic [5:0] FUNCT_OR   = 6'b100101;
    localparam logic [5:0] FUNCT_XOR  = 6'b100110;
    localparam logic [5:0] FUNCT_NOR  = 6'b100111;
    localparam logic [5:0] FUNCT_SLTU = 6'b101011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SUB  = 3'd1,
        ALU_AND  = 3'd2,
        ALU_OR   = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_NOR  = 3'd5,
        ALU_SLTU = 3'd6,
        ALU_SLLV = 3'd7
    } alu_op_t;

    typedef struct packed {
        logic    legal;
        alu_op_t op;
    } decode_t;

    // Anything that is not a listed R-type funct is flagged illegal.
    function automatic decode_t decode_rtype(input logic [31:0] inst);
        decode_t d;
        d.legal = 1'b1;
        d.op    = ALU_ADD;
        if (inst[31:26] != OP_RTYPE) begin
            d.legal = 1'b0;
        end else begin
            case (inst[5:0])
                FUNCT_ADD:  d.op = ALU_ADD;
                FUNCT_SUB:  d.op = ALU_SUB;
                FUNCT_AND:  d.op = ALU_AND;
                FUNCT_OR:   d.op = ALU_OR;
                FUNCT_XOR:  d.op = ALU_XOR;
                FUNCT_NOR:  d.op = ALU_NOR;
                FUNCT_SLTU: d.op = ALU_SLTU;
                FUNCT_SLLV: d.op = ALU_SLLV;
                default:    d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU for the R-type controller; OF is only meaningful for
// add/sub and is forced low for every other operation.
module mips_alu
    import mips_rtype_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  alu_op_t           ALU_OP,
    output logic [DATA_W-1:0] F,
    output logic              ZF,
    output logic              OF
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;

    assign sum  = A + B;
    assign diff = A - B;

    always_comb begin
        F  = '0;
        OF = 1'b0;
        case (ALU_OP)
            ALU_ADD: begin
                F  = sum;
                OF = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            ALU_SUB: begin
                F  = diff;
                OF = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            ALU_AND:  F = A & B;
            ALU_OR:   F = A | B;
            ALU_XOR:  F = A ^ B;
            ALU_NOR:  F = ~(A | B);
            ALU_SLTU: F = {{(DATA_W-1){1'b0}}, (A < B)};
            ALU_SLLV: F = B << A[4:0];
            default:  F = '0;
        endcase
    end

    assign ZF = (F == '0);

endmodule

// File: rtl/mips_rtype_exec.sv
// Four-state R-type controller: accept, read rs/rt from the register file,
// execute, then write rd back through the register file's write port.
module mips_rtype_exec
    import mips_rtype_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [31:0]       Inst_In,
    input  logic              Inst_Valid,
    output logic              Inst_Ready,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    input  logic [DATA_W-1:0] R_Data_A,
    input  logic [DATA_W-1:0] R_Data_B,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [DATA_W-1:0] W_Data,
    output logic              Write_Reg,
    output logic [DATA_W-1:0] Result,
    output logic              ZF,
    output logic              OF,
    output logic              Done,
    output logic              Illegal,
    output logic              Busy
);

    state_t            state;
    state_t            next_state;
    logic [31:0]       ir;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] result_q;
    logic              zf_q;
    logic              of_q;
    logic              illegal_q;
    logic              rd_zero_q;

    decode_t           dec;
    logic [DATA_W-1:0] alu_f;
    logic              alu_zf;
    logic              alu_of;

    assign dec = decode_rtype(ir);

    mips_alu #(.DATA_W(DATA_W)) u_alu (
        .A      (a_q),
        .B      (b_q),
        .ALU_OP (dec.op),
        .F      (alu_f),
        .ZF     (alu_zf),
        .OF     (alu_of)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (Inst_Valid) next_state = S_READ;
            S_READ:  next_state = S_EXEC;
            S_EXEC:  next_state = S_WB;
            S_WB:    next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Illegal instructions leave Result/ZF/OF untouched; only the flags move.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ir        <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            zf_q      <= 1'b0;
            of_q      <= 1'b0;
            illegal_q <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (Inst_Valid) ir <= Inst_In;
                S_READ: begin
                    a_q <= R_Data_A;
                    b_q <= R_Data_B;
                end
                S_EXEC: begin
                    illegal_q <= ~dec.legal;
                    rd_zero_q <= (ir[15:11] == 5'd0);
                    if (dec.legal) begin
                        result_q <= alu_f;
                        zf_q     <= alu_zf;
                        of_q     <= alu_of;
                    end
                end
                default: ;
            endcase
        end
    end

    // Reset gates the strobe so a write due on a resetting edge never lands.
    always_comb begin
        Inst_Ready = (state == S_IDLE);
        Busy       = (state != S_IDLE);
        Done       = (state == S_WB);
        Illegal    = (state == S_WB) && illegal_q;
        Write_Reg  = (state == S_WB) && !illegal_q && !rd_zero_q && !Reset;
    end

    assign R_Addr_A = ir[25:21];
    assign R_Addr_B = ir[20:16];
    assign W_Addr   = ir[15:11];
    assign W_Data   = result_q;
    assign Result   = result_q;
    assign ZF       = zf_q;
    assign OF       = of_q;

endmodule

// File: tb/tb_mips_rtype_exec.sv
// Scoreboard bench for mips_rtype_exec with a behavioural register file;
// stimulus pushes hand-computed expectations, a monitor checks each Done.
module tb_mips_rtype_exec;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Inst_In;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [4:0]  R_Addr_A;
    logic [4:0]  R_Addr_B;
    logic [31:0] R_Data_A;
    logic [31:0] R_Data_B;
    logic [4:0]  W_Addr;
    logic [31:0] W_Data;
    logic        Write_Reg;
    logic [31:0] Result;
    logic        ZF;
    logic        OF;
    logic        Done;
    logic        Illegal;
    logic        Busy;

    mips_rtype_exec #(.DATA_W(32), .ADDR_W(5)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Inst_In    (Inst_In),
        .Inst_Valid (Inst_Valid),
        .Inst_Ready (Inst_Ready),
        .R_Addr_A   (R_Addr_A),
        .R_Addr_B   (R_Addr_B),
        .R_Data_A   (R_Data_A),
        .R_Data_B   (R_Data_B),
        .W_Addr     (W_Addr),
        .W_Data     (W_Data),
        .Write_Reg  (Write_Reg),
        .Result     (Result),
        .ZF         (ZF),
        .OF         (OF),
        .Done       (Done),
        .Illegal    (Illegal),
        .Busy       (Busy)
    );

    always #5 Clk = ~Clk;

    logic [31:0] regs [32];
    logic        load_en   = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [31:0] load_data = '0;

    // Register file model: combinational reads with R0 hard-wired to zero.
    always @(posedge Clk) begin
        if (load_en)                       regs[load_addr] <= load_data;
        else if (Write_Reg && W_Addr != 0) regs[W_Addr]    <= W_Data;
    end
    assign R_Data_A = (R_Addr_A == 5'd0) ? 32'd0 : regs[R_Addr_A];
    assign R_Data_B = (R_Addr_B == 5'd0) ? 32'd0 : regs[R_Addr_B];

    int edge_cnt = 0;
    always @(posedge Clk) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic        wr;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ill;
        logic [31:0] res;
        logic        zf;
        logic        of;
        int          done_edge;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   compared   = 0;
    int   mismatched = 0;
    logic mon_en     = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic wr, input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic ill, input logic [31:0] res, input logic zf, input logic of);
        exp_t e;
        e.wr = wr; e.waddr = waddr; e.wdata = wdata; e.ill = ill;
        e.res = res; e.zf = zf; e.of = of; e.done_edge = 0;
        return e;
    endfunction

    task automatic loadReg(input logic [4:0] addr, input logic [31:0] data);
        @(negedge Clk);
        load_en = 1'b1; load_addr = addr; load_data = data;
        @(negedge Clk);
        load_en = 1'b0;
    endtask

    // Accept happens at the next rising edge, so WB falls three edges later.
    task automatic applyStimulus(input logic [31:0] inst, input exp_t e);
        int waited = 0;
        @(negedge Clk);
        while (!Inst_Ready && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        if (!Inst_Ready) begin
            checkOutput("ready_timeout", 32'(Inst_Ready), 32'd1);
            return;
        end
        Inst_In    = inst;
        Inst_Valid = 1'b1;
        e.done_edge = edge_cnt + 3;
        sb.push_back(e);
        @(negedge Clk);
        Inst_Valid = 1'b0;
    endtask

    task automatic drainQueue();
        int waited = 0;
        while (sb.size() != 0 && waited < 40) begin
            @(negedge Clk);
            waited++;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0);
        @(negedge Clk);
    endtask

    always @(negedge Clk) begin
        #1;
        if (mon_en) begin
            if (Done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 32'(Done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("done_edge", edge_cnt, mon_e.done_edge);
                    checkOutput("write_reg", 32'(Write_Reg), 32'(mon_e.wr));
                    if (mon_e.wr) begin
                        checkOutput("w_addr", 32'(W_Addr), 32'(mon_e.waddr));
                        checkOutput("w_data", W_Data, mon_e.wdata);
                    end
                    checkOutput("illegal", 32'(Illegal), 32'(mon_e.ill));
                    checkOutput("result", Result, mon_e.res);
                    checkOutput("zf", 32'(ZF), 32'(mon_e.zf));
                    checkOutput("of", 32'(OF), 32'(mon_e.of));
                end
            end else begin
                checkOutput("idle_write", 32'(Write_Reg), 32'd0);
                checkOutput("idle_illegal", 32'(Illegal), 32'd0);
            end
        end
    end

    initial begin
        int k1;
        int k2;
        int waited;
        exp_t e2;
        Reset = 1'b1; Inst_Valid = 1'b0; Inst_In = '0;
        repeat (2) @(negedge Clk);
        checkOutput("rst_busy",    32'(Busy),      32'd0);
        checkOutput("rst_done",    32'(Done),      32'd0);
        checkOutput("rst_write",   32'(Write_Reg), 32'd0);
        checkOutput("rst_illegal", 32'(Illegal),   32'd0);
        checkOutput("rst_result",  Result,         32'd0);
        checkOutput("rst_zf",      32'(ZF),        32'd0);
        checkOutput("rst_of",      32'(OF),        32'd0);
        Reset = 1'b0;
        @(negedge Clk);
        checkOutput("rst_ready", 32'(Inst_Ready), 32'd1);

        loadReg(5'd1, 32'h12345678);
        loadReg(5'd2, 32'h89ABCDEF);
        loadReg(5'd5, 32'h7FFFFFFF);
        loadReg(5'd6, 32'h00000001);
        mon_en = 1'b1;

        applyStimulus(32'h00221820, mk(1, 5'd3,  32'h9BE02467, 0, 32'h9BE02467, 0, 0));
        applyStimulus(32'h00212022, mk(1, 5'd4,  32'h00000000, 0, 32'h00000000, 1, 0));
        applyStimulus(32'h00A63820, mk(1, 5'd7,  32'h80000000, 0, 32'h80000000, 0, 1));
        applyStimulus(32'h8C220000, mk(0, 5'd0,  32'h0,        1, 32'h80000000, 0, 1));
        applyStimulus(32'h0022182A, mk(0, 5'd0,  32'h0,        1, 32'h80000000, 0, 1));
        applyStimulus(32'h00E67022, mk(1, 5'd14, 32'h7FFFFFFF, 0, 32'h7FFFFFFF, 0, 1));
        applyStimulus(32'h0022482B, mk(1, 5'd9,  32'h00000001, 0, 32'h00000001, 0, 0));
        applyStimulus(32'h00C15004, mk(1, 5'd10, 32'h2468ACF0, 0, 32'h2468ACF0, 0, 0));
        applyStimulus(32'h00005827, mk(1, 5'd11, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0));
        applyStimulus(32'h00216026, mk(1, 5'd12, 32'h00000000, 0, 32'h00000000, 1, 0));
        applyStimulus(32'h00226824, mk(1, 5'd13, 32'h00204468, 0, 32'h00204468, 0, 0));
        applyStimulus(32'h00220020, mk(0, 5'd0,  32'h0,        0, 32'h9BE02467, 0, 0));
        drainQueue();

        // Back-to-back issue with Inst_Valid held; second op reads R3 just written.
        loadReg(5'd3, 32'h00000000);
        @(negedge Clk);
        Inst_In = 32'h00221820; Inst_Valid = 1'b1;
        k1 = edge_cnt;
        e2 = mk(1, 5'd3, 32'h9BE02467, 0, 32'h9BE02467, 0, 0);
        e2.done_edge = k1 + 3;
        sb.push_back(e2);
        @(negedge Clk);
        Inst_In = 32'h00604025;
        waited = 0;
        while (!Inst_Ready && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        k2 = edge_cnt;
        checkOutput("issue_interval", k2 - k1, 32'd4);
        e2 = mk(1, 5'd8, 32'h9BE02467, 0, 32'h9BE02467, 0, 0);
        e2.done_edge = k2 + 3;
        sb.push_back(e2);
        @(negedge Clk);
        Inst_Valid = 1'b0;
        drainQueue();

        checkOutput("reg_r4",  regs[4],  32'h00000000);
        checkOutput("reg_r7",  regs[7],  32'h80000000);
        checkOutput("reg_r8",  regs[8],  32'h9BE02467);
        checkOutput("reg_r14", regs[14], 32'h7FFFFFFF);

        // Reset during EXEC must abandon the instruction before its write.
        loadReg(5'd3, 32'hCAFEF00D);
        @(negedge Clk);
        checkOutput("abort_ready", 32'(Inst_Ready), 32'd1);
        Inst_In = 32'h00221820; Inst_Valid = 1'b1;
        @(negedge Clk);
        Inst_Valid = 1'b0;
        @(negedge Clk);
        checkOutput("abort_busy_exec", 32'(Busy), 32'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        checkOutput("abort_busy",   32'(Busy),       32'd0);
        checkOutput("abort_ready2", 32'(Inst_Ready), 32'd1);
        checkOutput("abort_write",  32'(Write_Reg),  32'd0);
        checkOutput("abort_done",   32'(Done),       32'd0);
        checkOutput("abort_result", Result,          32'd0);
        repeat (5) @(negedge Clk);
        checkOutput("abort_r3", regs[3], 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
